// File: rtl/ram_copy_ctrl.sv
// rtl/ram_copy_ctrl.sv - Access master for the 16-bit word RAM: block copy or constant fill
module ram_copy_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic              ram_r,
    output logic              ram_w,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q
);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   i_q, i_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [ADDR_W:0]   i_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            fill_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            i_q     <= i_d;
            fill_q  <= fill_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        i_d     = i_q;
        fill_d  = fill_q;
        hold_d  = hold_q;
        i_inc   = i_q + {{ADDR_W{1'b0}}, 1'b1};
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = len;
                    fill_d = fill_val;
                    i_d    = '0;
                    if (len == '0)  state_d = FIN;
                    else if (mode)  state_d = WR;
                    else            state_d = RD;
                end
            end
            RD: begin
                hold_d  = ram_q;
                state_d = WR;
            end
            WR: begin
                i_d = i_inc;
                if (i_inc == len_q) state_d = FIN;
                else if (mode_q)    state_d = WR;
                else                state_d = RD;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state so address/data hold steady for the whole cycle.
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == FIN);
        ram_r    = (state_q == RD);
        ram_w    = (state_q == WR);
        ram_addr = '0;
        ram_d    = '0;
        if (state_q == RD) begin
            ram_addr = src_q + i_q[ADDR_W-1:0];
        end else if (state_q == WR) begin
            ram_addr = dst_q + i_q[ADDR_W-1:0];
            ram_d    = mode_q ? fill_q : hold_q;
        end
    end
endmodule

// File: tb/tb_ram_copy_ctrl.sv
// tb/tb_ram_copy_ctrl.sv - Scoreboard bench for ram_copy_ctrl against a behavioural 64x16 RAM
module tb_ram_copy_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, mode;
    logic [5:0]  src_addr, dst_addr;
    logic [6:0]  len;
    logic [15:0] fill_val;
    logic        busy, done, ram_r, ram_w;
    logic [5:0]  ram_addr;
    logic [15:0] ram_d, ram_q;

    logic [15:0] mem [64];
    logic [15:0] shadow [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    typedef struct packed {
        logic        w;
        logic [5:0]  addr;
        logic [15:0] data;
    } ev_t;
    ev_t sb[$];

    int total = 0;
    int passed = 0;

    ram_copy_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
        .busy(busy), .done(done), .ram_r(ram_r), .ram_w(ram_w),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)     mem[pre_addr] <= pre_data;
        else if (ram_w) mem[ram_addr] <= ram_d;
    end
    assign ram_q = mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic preload(input int a, input logic [15:0] v);
        pre_we = 1'b1; pre_addr = 6'(a); pre_data = v;
        @(negedge clk);
        pre_we = 1'b0;
        shadow[6'(a)] = v;
    endtask

    task automatic run_job(input logic m, input int src, input int dst, input int ln,
                           input logic [15:0] val, input int abort_at, input int restart_at,
                           input string tag);
        ev_t         ev;
        logic [15:0] d;
        int          nacc     = m ? ln : 2 * ln;
        int          limit    = (abort_at > 0) ? abort_at : nacc;
        int          exp_done = (ln == 0) ? 1 : (m ? ln + 1 : 2 * ln + 1);
        int          bound    = (abort_at > 0) ? abort_at + 4 : exp_done + 4;
        int          k        = 0;
        int          acc      = 0;
        bit          seen     = 0;
        for (int j = 0; j < ln && k < limit; j++) begin
            if (!m) begin
                ev.w = 1'b0; ev.addr = 6'(src + j); ev.data = '0;
                sb.push_back(ev); k++;
                d = shadow[6'(src + j)];
                if (k >= limit) break;
            end else begin
                d = val;
            end
            ev.w = 1'b1; ev.addr = 6'(dst + j); ev.data = d;
            sb.push_back(ev); k++;
            shadow[6'(dst + j)] = d;
        end
        start = 1'b1; mode = m; src_addr = 6'(src); dst_addr = 6'(dst);
        len = 7'(ln); fill_val = val;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= bound; c++) begin
            if (c == 1) check({tag, "_busy_rise"}, 32'(busy), 32'd1);
            if (ram_r && ram_w) check({tag, "_r_and_w"}, 32'(ram_r & ram_w), 32'd0);
            if (ram_r || ram_w) begin
                acc++;
                if (sb.size() == 0) begin
                    check({tag, "_extra_access_cycle"}, 32'(c), 32'd0);
                end else begin
                    ev = sb.pop_front();
                    check({tag, "_strobe_kind"}, 32'(ram_w), 32'(ev.w));
                    check({tag, "_addr"}, 32'(ram_addr), 32'(ev.addr));
                    if (ev.w) check({tag, "_wdata"}, 32'(ram_d), 32'(ev.data));
                end
            end
            if (done) begin
                seen = 1;
                check({tag, "_done_cycle"}, 32'(c), (abort_at > 0) ? 32'hFFFF_FFFF : 32'(exp_done));
            end
            if (abort_at > 0 && c == abort_at + 1) begin
                rst = 1'b0;
                check({tag, "_outputs_after_rst"},
                      32'({busy, done, ram_r, ram_w, ram_addr, ram_d}), 32'd0);
            end
            start = (c == restart_at);
            if (start) begin
                mode = ~m; len = 7'd1; dst_addr = 6'd0;
            end
            if (abort_at > 0 && c == abort_at) rst = 1'b1;
            if (abort_at == 0 && seen) break;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_pending_events"}, 32'(sb.size()), 32'd0);
        check({tag, "_access_count"}, 32'(acc), 32'(limit));
        if (abort_at == 0) begin
            check({tag, "_done_seen"}, 32'(seen), 32'd1);
            @(negedge clk);
            check({tag, "_idle_after"}, 32'({busy, done}), 32'd0);
        end
        sb.delete();
    endtask

    initial begin
        int bad;
        rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_val = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({busy, done, ram_r, ram_w, ram_addr, ram_d}), 32'd0);
        rst = 1'b0;
        for (int a = 0; a < 64; a++) preload(a, 16'h0000);

        run_job(1'b1, 0, 5, 3, 16'h00AA, 0, 0, "fill");
        run_job(1'b0, 5, 40, 3, 16'h0000, 0, 0, "readback");
        check("fill_mem5", 32'(mem[5]), 32'h00AA);
        check("fill_mem7", 32'(mem[7]), 32'h00AA);
        check("readback_mem42", 32'(mem[42]), 32'h00AA);

        preload(31, 16'h0100);
        preload(32, 16'h0040);
        run_job(1'b0, 31, 21, 2, 16'h0000, 0, 0, "copy");
        check("copy_mem21", 32'(mem[21]), 32'h0100);
        check("copy_mem22", 32'(mem[22]), 32'h0040);

        run_job(1'b1, 0, 62, 4, 16'h1234, 0, 0, "wrap");
        check("wrap_mem1", 32'(mem[1]), 32'h1234);
        check("wrap_mem2_untouched", 32'(mem[2]), 32'h0000);

        run_job(1'b0, 3, 3, 0, 16'h0000, 0, 0, "len0");
        run_job(1'b0, 48, 56, 8, 16'h0000, 0, 3, "busy_ignore");

        for (int a = 20; a < 28; a++) preload(a, 16'(16'h0100 + a - 20));
        run_job(1'b0, 20, 30, 8, 16'h0000, 5, 0, "abort");
        check("abort_mem30", 32'(mem[30]), 32'h0100);
        check("abort_mem31", 32'(mem[31]), 32'h0101);
        check("abort_mem32_untouched", 32'(mem[32]), 32'h0040);
        repeat (2) @(negedge clk);

        for (int a = 10; a < 14; a++) preload(a, 16'(a - 9));
        run_job(1'b0, 10, 11, 3, 16'h0000, 0, 0, "overlap");
        for (int a = 10; a < 14; a++) check($sformatf("overlap_mem%0d", a), 32'(mem[a]), 32'd1);

        bad = 0;
        for (int a = 0; a < 64; a++) if (mem[a] !== shadow[a]) bad++;
        check("final_mem_vs_model", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ram_copy_ctrl.md
# ram_copy_ctrl

Sequencing controller that drives the r/w/addr/D side of the team's 16-bit word RAM (RAM8 through RAM4K family) and consumes its read output. On a start request it either copies a block of words from a source address to a destination address, or fills a block with a constant. It is the access master for those RAMs, used by test and init logic in place of hand-driven r/w strobes.

## Interface
- ADDR_W, 6, RAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, RAM word width.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill; sampled with start.
- src_addr  in  ADDR_W  first source address (copy only).
- dst_addr  in  ADDR_W  first destination address.
- len  in  ADDR_W+1  word count, 0..2^ADDR_W.
- fill_val  in  DATA_W  fill constant (fill only).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- ram_r  out  1  RAM read strobe (to RAM r).
- ram_w  out  1  RAM write strobe (to RAM w).
- ram_addr  out  ADDR_W  RAM address.
- ram_d  out  DATA_W  RAM write data (to RAM D).
- ram_q  in  DATA_W  RAM read data (from RAM o); combinational from ram_addr/ram_r.

## Operation
- States: IDLE, RD, WR, FIN.
- On start=1 in IDLE, latch mode, src_addr, dst_addr, len, and fill_val into internal registers. Clear word index i to 0.
  - len=0 → FIN.
  - Else mode=0 → RD.
  - Else mode=1 → WR.
- RD: ram_r=1, ram_addr=src+i. At the cycle end, capture ram_q into a hold register. Next state: WR.
- WR: ram_w=1, ram_addr=dst+i, ram_d = hold (copy) or latched fill_val (fill). Increment i.
  - If i+1 == len → FIN.
  - Else → RD (copy) or WR (fill).
- FIN: done=1 for exactly one cycle, then → IDLE.
- Address arithmetic is ADDR_W bits, modulo 2^ADDR_W. A block crossing the top address wraps to 0.
- Copy is strictly ascending and word-at-a-time: each read is followed by its write before the next read.
  - Overlap with dst in (src, src+len) re-reads already-written words. This is defined behaviour, not an error.
- start while busy is ignored. Inputs are not re-sampled until the controller returns to IDLE.
- ram_r and ram_w are never high in the same cycle. Both are 0 in IDLE and FIN.
- In IDLE and FIN: ram_addr=0, ram_d=0.

## Timing
- Reset values: busy=0, done=0, ram_r=0, ram_w=0, ram_addr=0, ram_d=0, state=IDLE, i=0.
- Reset mid-operation returns to IDLE on the same edge. No further strobes follow, no done is produced, and a partially written block is left as is.
- Outputs are decoded from registered state, index and latched operands. There are no input-to-output combinational paths except ram_q → hold register.
- Start sampled at edge k:
  - copy: len RD/WR pairs occupy cycles k+1 .. k+2·len; done is high in cycle k+2·len+1.
  - fill: len WR cycles occupy k+1 .. k+len; done is high in cycle k+len+1.
  - len=0: done is high in cycle k+1.
- busy rises in cycle k+1 and falls after the FIN cycle.
- Next start is accepted at the first edge in IDLE, so there is one idle cycle minimum between jobs.
- The RAM write occurs while clk is high with ram_w, ram_addr and ram_d stable across the whole WR cycle. Each address/data set is held for one full clock period.

## Test plan
- Fill: reset, start mode=1 dst=5 len=3 fill_val=0x00AA → ram_w high cycles k+1..k+3 at addr 5,6,7; done in k+4. A following copy-read of addr 5..7 returns 0x00AA.
- Copy: preload addr 31=0x0100, 32=0x0040; start mode=0 src=31 dst=21 len=2 → RD31, WR21(0x0100), RD32, WR22(0x0040); done in cycle k+5.
- Wrap: start fill dst=62 len=4 val=0x1234 → writes at 62,63,0,1; no write to addr 2.
- len=0 and busy-ignore: start len=0 → done in k+1, no strobes. Assert start again during a len=8 copy → ignored; exactly 16 access cycles occur.
- Reset mid-op: start copy len=8, assert rst in cycle k+5 → all outputs 0 from the next edge; only words 0–1 written; no done.
- Overlap: preload 10..13 = 1,2,3,4; copy src=10 dst=11 len=3 → final 10..13 = 1,1,1,1.
